// File: rtl/cnn_frame_sequencer.sv
// Frame-level scheduler: loads one frame from the pixel FIFO, then starts each CNN layer in order.
// Each start waits for the previous layer's done pulse. A per-stage watchdog and out-of-order detection raise a sticky error.
module cnn_frame_sequencer #(
    parameter int H          = 24,
    parameter int W          = 24,
    parameter int D          = 1,
    parameter int NUM_STAGES = 8,
    parameter int TIMEOUT    = 65535,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  clear_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_ren_o,
    output logic                  pix_valid_o,
    output logic [NUM_STAGES-1:0] layer_start_o,
    input  logic [NUM_STAGES-1:0] stage_done_i,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic                  error_o,
    output logic [7:0]            err_stage_o,
    output logic [CNT_W-1:0]      cycle_count_o
);
    localparam int         PIXELS   = H * W * D;
    localparam int         RD_W     = $clog2(PIXELS + 1);
    localparam int         WD_W     = 20;
    localparam logic [7:0] LAST_IDX = 8'(NUM_STAGES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, ERR} state_t;

    state_t                state, state_next;
    logic [RD_W-1:0]       rd_cnt;
    logic [WD_W-1:0]       wd_cnt;
    logic [7:0]            idx;
    logic                  launch;
    logic                  pix_valid;
    logic [CNT_W-1:0]      cycle_cnt;
    logic [7:0]            err_stage;

    logic                  ren, load_done, done_hit, wrong_done, wd_fault;
    logic [NUM_STAGES-1:0] idx_mask;

    // launch marks the start-pulse cycle of a stage; a done seen in that same cycle is ignored.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        wrong_done = 1'b0;
        idx_mask   = NUM_STAGES'(1) << idx;
        ren        = (state == LOAD) && !fifo_empty_i && (rd_cnt < RD_W'(PIXELS));
        load_done  = (state == LOAD) && pix_valid && (rd_cnt == RD_W'(PIXELS));
        done_hit   = (state == RUN) && !launch && ((stage_done_i & idx_mask) != '0);
        case (state)
            IDLE, LOAD: wrong_done = |stage_done_i;
            RUN:        wrong_done = (stage_done_i & ~idx_mask) != '0;
            default:    wrong_done = 1'b0;
        endcase
        wd_fault = (wd_cnt == WD_W'(TIMEOUT - 1)) &&
                   (((state == LOAD) && !ren && !load_done) || ((state == RUN) && !done_hit));
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (wrong_done) state_next = ERR;
                  else if (start_i) state_next = LOAD;
            LOAD: if (wrong_done) state_next = ERR;
                  else if (load_done) state_next = RUN;
                  else if (wd_fault) state_next = ERR;
            RUN:  if (wrong_done) state_next = ERR;
                  else if (done_hit) state_next = (idx == LAST_IDX) ? DONE : RUN;
                  else if (wd_fault) state_next = ERR;
            DONE: state_next = IDLE;
            ERR:  if (clear_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt    <= '0;
            wd_cnt    <= '0;
            idx       <= '0;
            launch    <= 1'b0;
            pix_valid <= 1'b0;
            cycle_cnt <= '0;
            err_stage <= 8'hFF;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            pix_valid <= ren;
            launch    <= 1'b0;
            case (state)
                IDLE: if (state_next == LOAD) begin
                    rd_cnt    <= '0;
                    wd_cnt    <= '0;
                    cycle_cnt <= '0;
                end
                LOAD: begin
                    if (ren) rd_cnt <= rd_cnt + RD_W'(1);
                    wd_cnt <= ren ? '0 : wd_cnt + WD_W'(1);
                    if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);
                    if (state_next == RUN) begin
                        idx    <= '0;
                        launch <= 1'b1;
                        wd_cnt <= '0;
                    end
                end
                RUN: begin
                    if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);
                    if (done_hit && idx != LAST_IDX) begin
                        idx    <= idx + 8'd1;
                        launch <= 1'b1;
                        wd_cnt <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                default: ;
            endcase
            // Faults outside RUN are attributed to the load phase (0xFF).
            if (state_next == ERR && state != ERR) err_stage <= (state == RUN) ? idx : 8'hFF;
            else if (state == ERR && clear_i)      err_stage <= 8'hFF;
        end
    end

    always_comb begin
        fifo_ren_o    = ren;
        pix_valid_o   = pix_valid;
        layer_start_o = '0;
        if (state == RUN && launch) layer_start_o = idx_mask;
        busy_o        = (state == LOAD) || (state == RUN);
        frame_done_o  = (state == DONE);
        error_o       = (state == ERR);
        err_stage_o   = err_stage;
        cycle_count_o = cycle_cnt;
    end
endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Self-checking bench for cnn_frame_sequencer: randomized frames checked against an event-level model
// built from the frame rules (read count, start-after-done, frame_done timing, watchdog and fault rules).
module tb_cnn_frame_sequencer;
    localparam int H = 4, W = 4, D = 1, NS = 3, TO = 20, CW = 32;
    localparam int N = H * W * D;

    logic          clk = 1'b0;
    logic          reset, start_i, clear_i, fifo_empty_i;
    logic [NS-1:0] stage_done_i;
    logic          fifo_ren_o, pix_valid_o, busy_o, frame_done_o, error_o;
    logic [NS-1:0] layer_start_o;
    logic [7:0]    err_stage_o;
    logic [CW-1:0] cycle_count_o;

    int checks = 0;
    int errors = 0;

    cnn_frame_sequencer #(.H(H), .W(W), .D(D), .NUM_STAGES(NS), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .clear_i(clear_i), .fifo_empty_i(fifo_empty_i),
        .fifo_ren_o(fifo_ren_o), .pix_valid_o(pix_valid_o), .layer_start_o(layer_start_o),
        .stage_done_i(stage_done_i), .busy_o(busy_o), .frame_done_o(frame_done_o), .error_o(error_o),
        .err_stage_o(err_stage_o), .cycle_count_o(cycle_count_o)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_clear();
        next_cycle(); clear_i = 1'b1; stage_done_i = '0; start_i = 1'b0; settle();
        next_cycle(); clear_i = 1'b0; settle();
    endtask

    // Starts a frame with a never-empty FIFO and stops at the cycle layer_start_o[0] is seen.
    task automatic goto_run(output bit ok);
        ok = 1'b0;
        next_cycle(); start_i = 1'b1; clear_i = 1'b0; fifo_empty_i = 1'b0; stage_done_i = '0; settle();
        for (int i = 0; i < 40 && !ok; i++) begin
            next_cycle(); start_i = 1'b0; settle();
            ok = (layer_start_o === 3'b001);
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL goto_run layer_start[0] not seen within 40 cycles"); end
    endtask

    task automatic test_reset();
        reset = 1'b1; start_i = 1'b0; clear_i = 1'b0; fifo_empty_i = 1'b0; stage_done_i = '0;
        repeat (3) next_cycle();
        settle();
        checks += 8;
        if (fifo_ren_o !== 1'b0)    begin errors++; $display("FAIL reset_ren got %0b exp 0", fifo_ren_o); end
        if (pix_valid_o !== 1'b0)   begin errors++; $display("FAIL reset_pv got %0b exp 0", pix_valid_o); end
        if (layer_start_o !== '0)   begin errors++; $display("FAIL reset_ls got %b exp 000", layer_start_o); end
        if (busy_o !== 1'b0)        begin errors++; $display("FAIL reset_busy got %0b exp 0", busy_o); end
        if (frame_done_o !== 1'b0)  begin errors++; $display("FAIL reset_fd got %0b exp 0", frame_done_o); end
        if (error_o !== 1'b0)       begin errors++; $display("FAIL reset_err got %0b exp 0", error_o); end
        if (err_stage_o !== 8'hFF)  begin errors++; $display("FAIL reset_err_stage got %h exp ff", err_stage_o); end
        if (cycle_count_o !== '0)   begin errors++; $display("FAIL reset_cc got %0d exp 0", cycle_count_o); end
        next_cycle(); reset = 1'b0;
    endtask

    // One full frame against the reference model. Cycle k counts from 0 (start_i asserted).
    task automatic run_frame(input string tag, input int empty_pct, input int starve_at, input int starve_len,
                             input int min_lat, input int max_lat, input bit poke_start, input bit dup_done);
        int k, reads, obs_reads, start_due, done_at, fd_due, stage, streak, starve_left, ls0_cyc;
        bit loading, prev_ren, exp_ren, exp_pv, exp_busy, finished;
        logic [NS-1:0] exp_ls;
        reads = 0; obs_reads = 0; start_due = -1; done_at = -1; fd_due = -1; stage = 0; streak = 0;
        starve_left = starve_len; ls0_cyc = -1; loading = 1'b1; prev_ren = 1'b0; finished = 1'b0;
        next_cycle(); start_i = 1'b1; clear_i = 1'b0; fifo_empty_i = 1'b0; stage_done_i = '0; settle();
        for (k = 1; k < 800 && !finished; k++) begin
            next_cycle();
            start_i = poke_start ? 1'($urandom_range(1)) : 1'b0;
            if (loading && starve_len > 0 && reads == starve_at && starve_left > 0) begin
                fifo_empty_i = 1'b1; starve_left--;
            end else if (loading && streak < 8 && $urandom_range(99) < empty_pct) fifo_empty_i = 1'b1;
            else if (loading) fifo_empty_i = 1'b0;
            else fifo_empty_i = 1'($urandom_range(1));
            streak = fifo_empty_i ? streak + 1 : 0;
            stage_done_i = '0;
            if (k == done_at) stage_done_i[stage] = 1'b1;
            if (dup_done && k == start_due) stage_done_i[stage] = 1'b1;
            settle();

            exp_ren  = loading && !fifo_empty_i && reads < N;
            exp_pv   = prev_ren;
            exp_ls   = (k == start_due) ? NS'(1) << stage : '0;
            exp_busy = (fd_due < 0) || (k < fd_due);
            if (fifo_ren_o === 1'b1) obs_reads++;
            if (layer_start_o[0] === 1'b1 && ls0_cyc < 0) ls0_cyc = k;
            checks += 7;
            if (fifo_ren_o !== exp_ren)   begin errors++; $display("FAIL %s ren k=%0d got %0b exp %0b", tag, k, fifo_ren_o, exp_ren); end
            if (pix_valid_o !== exp_pv)   begin errors++; $display("FAIL %s pv k=%0d got %0b exp %0b", tag, k, pix_valid_o, exp_pv); end
            if (layer_start_o !== exp_ls) begin errors++; $display("FAIL %s ls k=%0d got %b exp %b", tag, k, layer_start_o, exp_ls); end
            if (busy_o !== exp_busy)      begin errors++; $display("FAIL %s busy k=%0d got %0b exp %0b", tag, k, busy_o, exp_busy); end
            if (frame_done_o !== (k == fd_due)) begin errors++; $display("FAIL %s fd k=%0d got %0b exp %0b", tag, k, frame_done_o, k == fd_due); end
            if (error_o !== 1'b0)         begin errors++; $display("FAIL %s err k=%0d got %0b exp 0", tag, k, error_o); end
            if (cycle_count_o !== 32'(k - 1)) begin errors++; $display("FAIL %s cc k=%0d got %0d exp %0d", tag, k, cycle_count_o, k - 1); end

            if (loading && exp_pv && reads == N) begin loading = 1'b0; start_due = k + 1; stage = 0; end
            if (exp_ren) reads++;
            if (k == start_due) done_at = k + int'($urandom_range(max_lat, min_lat));
            if (k == done_at) begin
                if (stage < NS - 1) begin stage++; start_due = k + 1; end
                else fd_due = k + 1;
            end
            if (k == fd_due) finished = 1'b1;
            prev_ren = exp_ren;
        end
        checks += 2;
        if (!finished) begin errors++; $display("FAIL %s frame_timeout no frame_done within budget", tag); end
        if (obs_reads !== N) begin errors++; $display("FAIL %s read_count got %0d exp %0d", tag, obs_reads, N); end
        if (empty_pct == 0) begin
            checks++;
            if (ls0_cyc !== N + 2 + starve_len) begin errors++; $display("FAIL %s ls0_cycle got %0d exp %0d", tag, ls0_cyc, N + 2 + starve_len); end
        end
        start_i = 1'b0; stage_done_i = '0;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); settle();
            checks += 3;
            if (frame_done_o !== 1'b0) begin errors++; $display("FAIL %s post_fd got %0b exp 0", tag, frame_done_o); end
            if (busy_o !== 1'b0)       begin errors++; $display("FAIL %s post_busy got %0b exp 0", tag, busy_o); end
            if (cycle_count_o !== 32'(fd_due - 1)) begin errors++; $display("FAIL %s cc_hold got %0d exp %0d", tag, cycle_count_o, fd_due - 1); end
        end
    endtask

    task automatic test_nominal();
        run_frame("nominal", 0, 0, 0, 2, 2, 1'b0, 1'b0);
    endtask

    task automatic test_starvation();
        run_frame("starve", 0, 5, 10, 1, 5, 1'b0, 1'b0);
    endtask

    task automatic test_random_frames();
        for (int i = 0; i < 4; i++) run_frame("random", 35, 0, 0, 1, 12, 1'b0, 1'($urandom_range(1)));
    endtask

    task automatic test_busy_ignores_start();
        run_frame("busy", 20, 0, 0, 1, 6, 1'b1, 1'b1);
    endtask

    task automatic test_timeout();
        bit ok;
        goto_run(ok);
        next_cycle(); settle();
        next_cycle(); stage_done_i = 3'b001; settle();
        next_cycle(); stage_done_i = '0; settle();
        checks++;
        if (layer_start_o !== 3'b010) begin errors++; $display("FAIL timeout_ls1 got %b exp 010", layer_start_o); end
        for (int j = 1; j <= TO; j++) begin
            next_cycle(); settle();
            checks++;
            if (error_o !== (j == TO)) begin errors++; $display("FAIL timeout_err j=%0d got %0b exp %0b", j, error_o, j == TO); end
        end
        checks += 3;
        if (err_stage_o !== 8'd1)   begin errors++; $display("FAIL timeout_stage got %0d exp 1", err_stage_o); end
        if (layer_start_o !== '0)   begin errors++; $display("FAIL timeout_ls got %b exp 000", layer_start_o); end
        if (busy_o !== 1'b0)        begin errors++; $display("FAIL timeout_busy got %0b exp 0", busy_o); end
        do_clear();
        checks += 2;
        if (error_o !== 1'b0)      begin errors++; $display("FAIL timeout_clear err got %0b exp 0", error_o); end
        if (err_stage_o !== 8'hFF) begin errors++; $display("FAIL timeout_clear stage got %h exp ff", err_stage_o); end
    endtask

    task automatic test_load_timeout();
        next_cycle(); start_i = 1'b1; fifo_empty_i = 1'b1; stage_done_i = '0; settle();
        for (int k = 1; k <= TO + 1; k++) begin
            next_cycle(); start_i = 1'b0; settle();
            checks += 2;
            if (fifo_ren_o !== 1'b0) begin errors++; $display("FAIL load_to_ren k=%0d got %0b exp 0", k, fifo_ren_o); end
            if (error_o !== (k == TO + 1)) begin errors++; $display("FAIL load_to_err k=%0d got %0b exp %0b", k, error_o, k == TO + 1); end
        end
        checks++;
        if (err_stage_o !== 8'hFF) begin errors++; $display("FAIL load_to_stage got %h exp ff", err_stage_o); end
        fifo_empty_i = 1'b0;
        do_clear();
        checks++;
        if (error_o !== 1'b0) begin errors++; $display("FAIL load_to_clear got %0b exp 0", error_o); end
    endtask

    task automatic test_out_of_order();
        bit ok;
        logic [NS-1:0] bad;
        goto_run(ok);
        next_cycle(); stage_done_i = 3'b010; settle();
        next_cycle(); stage_done_i = '0; settle();
        checks += 4;
        if (error_o !== 1'b1)     begin errors++; $display("FAIL ooo_err got %0b exp 1", error_o); end
        if (err_stage_o !== 8'd0) begin errors++; $display("FAIL ooo_stage got %0d exp 0", err_stage_o); end
        if (busy_o !== 1'b0)      begin errors++; $display("FAIL ooo_busy got %0b exp 0", busy_o); end
        if (fifo_ren_o !== 1'b0)  begin errors++; $display("FAIL ooo_ren got %0b exp 0", fifo_ren_o); end
        for (int i = 0; i < 5; i++) begin
            next_cycle(); stage_done_i = (i == 0) ? 3'b001 : '0; start_i = 1'b1; settle();
            checks += 2;
            if (layer_start_o !== '0) begin errors++; $display("FAIL ooo_no_start i=%0d got %b exp 000", i, layer_start_o); end
            if (error_o !== 1'b1)     begin errors++; $display("FAIL ooo_sticky i=%0d got %0b exp 1", i, error_o); end
        end
        next_cycle(); stage_done_i = '0; clear_i = 1'b1; start_i = 1'b1; settle();
        next_cycle(); clear_i = 1'b0; start_i = 1'b0; settle();
        checks += 3;
        if (error_o !== 1'b0)      begin errors++; $display("FAIL ooo_clear err got %0b exp 0", error_o); end
        if (err_stage_o !== 8'hFF) begin errors++; $display("FAIL ooo_clear stage got %h exp ff", err_stage_o); end
        if (busy_o !== 1'b0)       begin errors++; $display("FAIL ooo_clear_start busy got %0b exp 0", busy_o); end
        next_cycle(); settle();
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL ooo_start_ignored busy got %0b exp 0", busy_o); end

        // Correct and wrong done together on stage 1: the fault must win.
        goto_run(ok);
        next_cycle(); settle();
        next_cycle(); stage_done_i = 3'b001; settle();
        next_cycle(); stage_done_i = '0; settle();
        bad = ($urandom_range(1) != 0) ? 3'b100 : 3'b001;
        next_cycle(); stage_done_i = 3'b010 | bad; settle();
        next_cycle(); stage_done_i = '0; settle();
        checks += 3;
        if (error_o !== 1'b1)     begin errors++; $display("FAIL both_err got %0b exp 1", error_o); end
        if (err_stage_o !== 8'd1) begin errors++; $display("FAIL both_stage got %0d exp 1", err_stage_o); end
        if (layer_start_o !== '0) begin errors++; $display("FAIL both_ls got %b exp 000", layer_start_o); end
        do_clear();
    endtask

    task automatic test_reset_mid_load();
        int fd_seen, busy_seen;
        next_cycle(); start_i = 1'b1; fifo_empty_i = 1'b0; stage_done_i = '0; settle();
        repeat (3 + $urandom_range(6)) begin next_cycle(); start_i = 1'b0; end
        settle();
        checks++;
        if (fifo_ren_o !== 1'b1) begin errors++; $display("FAIL rst_mid_precond ren got %0b exp 1", fifo_ren_o); end
        next_cycle(); reset = 1'b1; settle();
        next_cycle(); reset = 1'b0; settle();
        checks += 6;
        if (fifo_ren_o !== 1'b0)   begin errors++; $display("FAIL rst_mid_ren got %0b exp 0", fifo_ren_o); end
        if (pix_valid_o !== 1'b0)  begin errors++; $display("FAIL rst_mid_pv got %0b exp 0", pix_valid_o); end
        if (busy_o !== 1'b0)       begin errors++; $display("FAIL rst_mid_busy got %0b exp 0", busy_o); end
        if (layer_start_o !== '0)  begin errors++; $display("FAIL rst_mid_ls got %b exp 000", layer_start_o); end
        if (cycle_count_o !== '0)  begin errors++; $display("FAIL rst_mid_cc got %0d exp 0", cycle_count_o); end
        if (err_stage_o !== 8'hFF) begin errors++; $display("FAIL rst_mid_stage got %h exp ff", err_stage_o); end
        fd_seen = 0; busy_seen = 0;
        for (int i = 0; i < 30; i++) begin
            next_cycle(); settle();
            if (frame_done_o === 1'b1 || layer_start_o !== '0) fd_seen++;
            if (busy_o === 1'b1) busy_seen++;
        end
        checks += 2;
        if (fd_seen !== 0)   begin errors++; $display("FAIL rst_mid_no_pulses got %0d exp 0", fd_seen); end
        if (busy_seen !== 0) begin errors++; $display("FAIL rst_mid_stays_idle got %0d exp 0", busy_seen); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_starvation();
        test_random_frames();
        test_busy_ignores_start();
        test_timeout();
        test_load_timeout();
        test_out_of_order();
        test_reset_mid_load();
        test_nominal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
